apb_requester: RTL and testbench
================================

# apb_requester

Bridges a simple valid/ready host request port onto an APB4 bus as the requester (manager), the opposite end of the link from our APB completer. It accepts one host request at a time and runs the APB SETUP/ACCESS sequence, honouring completer wait states and PSLVERR. It returns read data and error status on a held response port. A configurable wait-state timeout ends a hung transfer with an error so the host never deadlocks.

## Interface
- ADDR_WIDTH, 32, PADDR / req_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; PSTRB width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles per transfer; 0 disables the timeout

Ports:
- PCLK  in  1  single clock
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  request accepted on an edge where req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address, forwarded unchanged
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte strobes
- req_prot  in  3  forwarded to PPROT
- rsp_valid  out  1  response held until consumed
- rsp_ready  in  1  host consumes response
- rsp_rdata  out  DATA_WIDTH  captured PRDATA; 0 for writes, errors and timeouts
- rsp_error  out  1  PSLVERR seen, or timeout
- rsp_timeout  out  1  transfer ended by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PPROT  out  3
- PREADY, PSLVERR  in  1 each; PRDATA  in  DATA_WIDTH

## Operation
- State machine states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - req_ready=1.
  - On acceptance, latch write, addr, wdata, strb and prot into registers, then go to SETUP.
  - If write=0, the latched strb is forced to 0 (APB4 read rule).
- SETUP: PSEL=1, PENABLE=0. Always goes to ACCESS. Clear the timeout counter.
- ACCESS
  - PSEL=1, PENABLE=1.
  - If PREADY=1: capture PSLVERR into rsp_error. If this is a read with PSLVERR=0, capture PRDATA into rsp_rdata; otherwise rsp_rdata=0. Go to RESP.
  - If PREADY=0 and TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1: set rsp_error=1, rsp_timeout=1, rsp_rdata=0, and go to RESP.
  - If PREADY=0 otherwise: counter++ and stay in ACCESS.
  - PREADY=1 in the final timeout cycle is a normal completion, not a timeout.
- RESP
  - rsp_valid=1, PSEL=0, PENABLE=0.
  - On rsp_ready=1, go to IDLE and clear rsp_error, rsp_timeout and rsp_rdata.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT come straight from the latched registers. They stay stable from SETUP through the end of ACCESS, and keep their values in RESP and IDLE.
- PSLVERR and PRDATA are ignored except in ACCESS when PREADY=1.
- No address decode, alignment checks or request buffering. Range and alignment checking belong to the completer.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset values: all outputs 0, except req_ready=1 (state is IDLE).
- Request accepted at edge N:
  - SETUP during cycle N+1.
  - ACCESS from cycle N+2.
  - With zero wait states, rsp_valid rises in cycle N+3.
  - Each wait state adds one cycle.
- If rsp_ready is already high when rsp_valid rises, the block is in IDLE the following cycle.
- Minimum period is 4 cycles per transfer. req_ready=0 in SETUP, ACCESS and RESP, so there is no back-to-back pipelining.
- A timeout asserts rsp_valid TIMEOUT_CYCLES+2 cycles after acceptance.
- Asserting PRESETn low in any state returns every output to its reset value immediately (asynchronous). Any in-flight transfer is dropped with no response.

## Test plan
- Zero-wait write: addr 0x8000_0004, wdata 0xDEAD_BEEF, strb 0xF. Required: SETUP at N+1 with PSEL=1, PENABLE=0; ACCESS at N+2; rsp_valid at N+3 with rsp_error=0 and rsp_rdata=0.
- Read with 3 wait states, PRDATA 0x1234_5678: rsp_valid at N+6 with rsp_rdata=0x1234_5678. PSTRB=0 throughout. PADDR stable for all ACCESS cycles.
- Error read: PREADY=1 with PSLVERR=1 and PRDATA 0xFFFF_FFFF. Required: rsp_error=1, rsp_timeout=0, rsp_rdata=0.
- Timeout with TIMEOUT_CYCLES=4 and PREADY stuck at 0: exactly 4 ACCESS cycles, PSEL drops, then rsp_error=1, rsp_timeout=1. Repeat with PREADY=1 on the 4th cycle: normal completion with rsp_timeout=0.
- Response backpressure: rsp_ready held 0 for 5 cycles. rsp_valid and its data stay stable, req_ready=0, and a pending req_valid is not accepted until the cycle after rsp_ready=1.
- Reset mid-ACCESS: PRESETn low during a wait state. All outputs return to reset values immediately. After release, req_ready=1 and a new transfer completes normally.

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: turns one valid/ready host request at a time into an APB SETUP/ACCESS transfer.
// It returns a held response, and a wait-state timeout guarantees the host always gets an answer.
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  // A disabled timeout still keeps a 1-bit counter so no zero-width vector exists.
  localparam int CNT_W = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);

  // NOTE: every register is written with non-blocking assignments so all of them update together on the edge.
  // The APB address/data registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PSTRB  <= req_write ? req_strb : '0;
            PPROT  <= req_prot;
            state  <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_error <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state     <= RESP;
          end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= RESP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Randomized self-checking bench for apb_requester. The bench plays the APB completer and the host.
// Expected latency and response fields come from a transaction-level model of the wait/timeout rules.
module tb_apb_requester;

  localparam int T = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  int n_total = 0;
  int n_pass  = 0;

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Completer inputs outside a completing ACCESS cycle must be ignored, so fill them with noise.
  task automatic bus_noise();
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 1);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 0);
    check({pfx, "_rsp_error"}, rsp_error, 0);
    check({pfx, "_rsp_timeout"}, rsp_timeout, 0);
    check({pfx, "_psel"}, PSEL, 0);
    check({pfx, "_penable"}, PENABLE, 0);
    check({pfx, "_pwrite"}, PWRITE, 0);
    check({pfx, "_paddr"}, PADDR, 0);
    check({pfx, "_pwdata"}, PWDATA, 0);
    check({pfx, "_pstrb"}, PSTRB, 0);
    check({pfx, "_pprot"}, PPROT, 0);
  endtask

  // One full host transaction; called at a negedge with the DUT idle, returns at a negedge with it idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic err, input logic [31:0] rdata, input int hold);
    logic [3:0]  exp_strb;
    logic        exp_to;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n_acc;
    exp_strb = wr ? strb : 4'h0;
    exp_to   = (waits >= T);
    exp_err  = exp_to || err;
    exp_rd   = (!wr && !exp_to && !err) ? rdata : 32'h0;
    n_acc    = exp_to ? T : waits + 1;

    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb; req_prot = prot;
    bus_noise();
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_strb = 4'($urandom); req_prot = 3'($urandom);
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_req_ready", req_ready, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_pstrb", PSTRB, exp_strb);
    check("setup_pprot", PPROT, prot);
    bus_noise();
    for (int k = 0; k < n_acc; k++) begin
      @(negedge PCLK);
      check("access_psel", PSEL, 1);
      check("access_penable", PENABLE, 1);
      check("access_rsp_valid", rsp_valid, 0);
      check("access_paddr", PADDR, addr);
      check("access_pwdata", PWDATA, wdata);
      check("access_pstrb", PSTRB, exp_strb);
      if (k == waits) begin
        PREADY = 1'b1; PSLVERR = err; PRDATA = rdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
    end
    @(negedge PCLK);
    bus_noise();
    check("resp_valid", rsp_valid, 1);
    check("resp_psel", PSEL, 0);
    check("resp_penable", PENABLE, 0);
    check("resp_req_ready", req_ready, 0);
    check("resp_error", rsp_error, exp_err);
    check("resp_timeout", rsp_timeout, exp_to);
    check("resp_rdata", rsp_rdata, exp_rd);
    check("resp_paddr", PADDR, addr);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = $urandom;
      @(negedge PCLK);
      bus_noise();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, exp_rd);
      check("hold_rsp_error", rsp_error, exp_err);
      check("hold_req_ready", req_ready, 0);
      check("hold_psel", PSEL, 0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_req_ready", req_ready, 1);
    check("done_psel", PSEL, 0);
    check("done_rsp_error", rsp_error, 0);
    check("done_rsp_timeout", rsp_timeout, 0);
    check("done_rsp_rdata", rsp_rdata, 0);
    check("done_paddr", PADDR, addr);
    req_valid = 1'b0;
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_reset_outputs("post_reset");

    // Directed cases from the test plan.
    xfer(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 0);
    xfer(1'b0, 32'h0000_0200, 32'h0, 4'h3, 3'd1, 0, 1'b1, 32'hFFFF_FFFF, 1);
    xfer(1'b0, 32'h0000_0300, 32'h0, 4'h0, 3'd0, 100, 1'b0, 32'hAAAA_5555, 0);
    xfer(1'b0, 32'h0000_0304, 32'h0, 4'h0, 3'd0, T - 1, 1'b0, 32'h5A5A_A5A5, 0);
    xfer(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'h5, 3'd7, 1, 1'b0, 32'h0, 5);

    // Reset in the middle of a wait state.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0500; req_prot = 3'd3;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    PREADY = 1'b0;
    @(negedge PCLK);
    PREADY = 1'b0;
    @(negedge PCLK);
    check("mid_access_psel", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("after_reset_req_ready", req_ready, 1);
    check("after_reset_psel", PSEL, 0);
    xfer(1'b1, 32'h0000_0600, 32'h0BAD_F00D, 4'hC, 3'd4, 2, 1'b0, 32'h0, 0);

    // Randomized transactions across the wait/error/timeout/backpressure space.
    for (int i = 0; i < 30; i++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, T + 2)), 1'($urandom_range(0, 3) == 0), $urandom,
           int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
